// File: rtl/tg_bus_event_capture.sv
// Cartridge bus event capture: synchronizes and de-glitches the bus strobes, turns completed
// write cycles (and optionally read cycles) into events, and queues them in a FWFT FIFO.
module tg_bus_event_capture #(
    parameter int unsigned FILT     = 3,
    parameter int unsigned DEPTH    = 4,
    parameter bit          CAP_RD   = 1'b0,
    parameter logic [20:0] WIN_MASK = 21'h100000,
    parameter logic [20:0] WIN_BASE = 21'h000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [20:0] tg_a,
    input  logic [7:0]  tg_d,
    input  logic        tg_oe_n,
    input  logic        tg_we_n,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic        ev_wr,
    output logic [20:0] ev_addr,
    output logic [7:0]  ev_data,
    output logic [4:0]  level,
    output logic        ovf,
    output logic [7:0]  drop_cnt,
    input  logic        ovf_clr
);

    localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  FILT_LAST = 4'(FILT - 1);
    localparam logic [3:0]  FILT_CNT  = 4'(FILT);
    localparam logic [4:0]  DEPTH_L   = 5'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        StDisarm,
        StIdle,
        StWrAct,
        StRdAct
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and pin register stage
    // ------------------------------------------------------------------
    logic        oe_s1_q, oe_s2_q, we_s1_q, we_s2_q;
    logic [20:0] a_q;
    logic [7:0]  d_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            oe_s1_q <= 1'b1;
            oe_s2_q <= 1'b1;
            we_s1_q <= 1'b1;
            we_s2_q <= 1'b1;
            a_q     <= '0;
            d_q     <= '0;
        end else begin
            oe_s1_q <= tg_oe_n;
            oe_s2_q <= oe_s1_q;
            we_s1_q <= tg_we_n;
            we_s2_q <= we_s1_q;
            a_q     <= tg_a;
            d_q     <= tg_d;
        end
    end

    // ------------------------------------------------------------------
    // Glitch filters: level follows only after FILT consecutive samples
    // ------------------------------------------------------------------
    logic       oe_f_q, we_f_q;
    logic [3:0] oe_cnt_q, we_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            oe_f_q   <= 1'b1;
            we_f_q   <= 1'b1;
            oe_cnt_q <= '0;
            we_cnt_q <= '0;
        end else begin
            if (oe_s2_q == oe_f_q) begin
                oe_cnt_q <= '0;
            end else if (oe_cnt_q == FILT_LAST) begin
                oe_f_q   <= oe_s2_q;
                oe_cnt_q <= '0;
            end else begin
                oe_cnt_q <= oe_cnt_q + 4'd1;
            end

            if (we_s2_q == we_f_q) begin
                we_cnt_q <= '0;
            end else if (we_cnt_q == FILT_LAST) begin
                we_f_q   <= we_s2_q;
                we_cnt_q <= '0;
            end else begin
                we_cnt_q <= we_cnt_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arming: the filters start at "deasserted" out of reset, so DISARM waits
    // until FILT real (post-reset) synchronized samples show both strobes high.
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [1:0] warm_q;
    logic [3:0] arm_cnt_q;
    logic       armed;

    assign armed = (arm_cnt_q == FILT_CNT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            warm_q    <= '0;
            arm_cnt_q <= '0;
        end else begin
            warm_q <= {warm_q[0], 1'b1};
            if ((state_q != StDisarm) || !warm_q[1] || !(we_s2_q && oe_s2_q)) begin
                arm_cnt_q <= '0;
            end else if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus cycle FSM
    // ------------------------------------------------------------------
    logic        cap_en;
    logic        push_req;
    logic        push_wr;
    logic [20:0] push_addr;
    logic [7:0]  push_data;
    logic [20:0] cap_addr_q;
    logic [7:0]  cap_data_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StDisarm;
            cap_addr_q <= '0;
            cap_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                cap_addr_q <= a_q;
                cap_data_q <= d_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_en    = 1'b0;
        push_req  = 1'b0;
        push_wr   = 1'b0;
        push_addr = cap_addr_q;
        push_data = cap_data_q;
        case (state_q)
            StDisarm: begin
                if (armed && we_f_q && oe_f_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (!we_f_q) begin
                    state_d = StWrAct;
                    cap_en  = 1'b1;
                end else if (!oe_f_q) begin
                    state_d   = StRdAct;
                    push_req  = CAP_RD;
                    push_addr = a_q;
                    push_data = '0;
                end
            end
            StWrAct: begin
                if (we_f_q) begin
                    state_d  = StIdle;
                    push_req = 1'b1;
                    push_wr  = 1'b1;
                end else begin
                    cap_en = 1'b1;
                end
            end
            StRdAct: begin
                // A write taking over a read cycle must not emit another read event
                if (!we_f_q) begin
                    state_d = StWrAct;
                    cap_en  = 1'b1;
                end else if (oe_f_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StDisarm;
        endcase
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic          mem_wr   [DEPTH];
    logic [20:0]   mem_addr [DEPTH];
    logic [7:0]    mem_data [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q;
    logic [7:0]    drop_q;
    logic          ovf_q;
    logic          in_win, push, pop, full, push_ok, drop;

    assign in_win  = ((push_addr & WIN_MASK) == WIN_BASE);
    assign push    = push_req && in_win;
    assign full    = (count_q == DEPTH_L);
    assign pop     = ev_valid && ev_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_wr[wr_ptr_q]   <= push_wr;
            mem_addr[wr_ptr_q] <= push_addr;
            mem_data[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Clear has priority over a coincident drop
    always_ff @(posedge CLK) begin
        if (RST || ovf_clr) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Head fields read as zero while the FIFO is empty
    assign ev_valid = (count_q != 5'd0);
    assign ev_wr    = ev_valid & mem_wr[rd_ptr_q];
    assign ev_addr  = ev_valid ? mem_addr[rd_ptr_q] : 21'd0;
    assign ev_data  = ev_valid ? mem_data[rd_ptr_q] : 8'd0;
    assign level    = count_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_tg_bus_event_capture.sv
// Randomized self-checking bench for tg_bus_event_capture; a queue-based event model predicts
// FIFO contents, level and overflow state from completed bus cycles.
module tb_tg_bus_event_capture;

    localparam int unsigned FILT     = 3;
    localparam int unsigned DEPTH    = 4;
    localparam logic [20:0] WIN_MASK = 21'h100000;
    localparam logic [20:0] WIN_BASE = 21'h000000;

    logic        CLK = 1'b0;
    logic        RST;
    logic [20:0] tg_a;
    logic [7:0]  tg_d;
    logic        tg_oe_n, tg_we_n;
    logic        ev_valid, ev_ready, ev_wr;
    logic [20:0] ev_addr;
    logic [7:0]  ev_data;
    logic [4:0]  level;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        ovf_clr;

    tg_bus_event_capture #(
        .FILT    (FILT),
        .DEPTH   (DEPTH),
        .CAP_RD  (1'b1),
        .WIN_MASK(WIN_MASK),
        .WIN_BASE(WIN_BASE)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .tg_a    (tg_a),
        .tg_d    (tg_d),
        .tg_oe_n (tg_oe_n),
        .tg_we_n (tg_we_n),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_wr   (ev_wr),
        .ev_addr (ev_addr),
        .ev_data (ev_data),
        .level   (level),
        .ovf     (ovf),
        .drop_cnt(drop_cnt),
        .ovf_clr (ovf_clr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit        wr;
        bit [20:0] addr;
        bit [7:0]  data;
    } ev_t;

    ev_t q[$];
    bit  m_ovf;
    int  m_drop;
    int  checks = 0;
    int  errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic void model_push(input bit wr, input bit [20:0] a, input bit [7:0] d);
        ev_t e;
        if ((a & WIN_MASK) != WIN_BASE) return;
        if (q.size() < DEPTH) begin
            e.wr = wr;
            e.addr = a;
            e.data = d;
            q.push_back(e);
        end else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
    endfunction

    function automatic void model_clear();
        m_ovf = 1'b0;
        m_drop = 0;
    endfunction

    // One bus cycle with the strobe low for 'width' clocks, then enough idle time to settle
    task automatic bus_op(input bit wr, input bit [20:0] a, input bit [7:0] d, input int width);
        tg_a = a;
        tg_d = d;
        if (wr) tg_we_n = 1'b0;
        else tg_oe_n = 1'b0;
        cyc(width);
        tg_we_n = 1'b1;
        tg_oe_n = 1'b1;
        if (width >= FILT) model_push(wr, a, wr ? d : 8'h00);
        cyc(FILT + 8);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_level"}, 32'(level), 32'(q.size()));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        check_eq({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1 && q.size() > 0; i++) begin
            check_eq({tag, "_valid"}, 32'(ev_valid), 32'd1);
            check_eq({tag, "_wr"}, 32'(ev_wr), 32'(q[0].wr));
            check_eq({tag, "_addr"}, 32'(ev_addr), 32'(q[0].addr));
            check_eq({tag, "_data"}, 32'(ev_data), 32'(q[0].data));
            ev_ready = 1'b1;
            cyc(1);
            ev_ready = 1'b0;
            void'(q.pop_front());
        end
        check_eq({tag, "_empty_level"}, 32'(level), 32'd0);
        check_eq({tag, "_empty_valid"}, 32'(ev_valid), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int n_ev, first_i;
        logic        s_wr;
        logic [20:0] s_addr;
        logic [7:0]  s_data;

        RST = 1'b1;
        tg_a = '0;
        tg_d = '0;
        tg_oe_n = 1'b1;
        tg_we_n = 1'b1;
        ev_ready = 1'b0;
        ovf_clr = 1'b0;
        model_clear();
        cyc(3);
        check_eq("rst_valid", 32'(ev_valid), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("rst_wr", 32'(ev_wr), 32'd0);
        check_eq("rst_addr", 32'(ev_addr), 32'd0);
        check_eq("rst_data", 32'(ev_data), 32'd0);
        RST = 1'b0;
        cyc(10);

        // Single write with the consumer always ready: one event, bounded latency
        tg_a = 21'h01234;
        tg_d = 8'hA5;
        ev_ready = 1'b1;
        tg_we_n = 1'b0;
        cyc(10);
        tg_we_n = 1'b1;
        n_ev = 0;
        first_i = 0;
        s_wr = 1'b0;
        s_addr = '0;
        s_data = '0;
        for (int i = 1; i <= 15; i++) begin
            cyc(1);
            if (ev_valid) begin
                n_ev++;
                if (first_i == 0) begin
                    first_i = i;
                    s_wr = ev_wr;
                    s_addr = ev_addr;
                    s_data = ev_data;
                end
            end
        end
        ev_ready = 1'b0;
        check_eq("wr_count", 32'(n_ev), 32'd1);
        check_eq("wr_latency_ok", 32'(first_i >= 1 && first_i <= 2 + FILT + 1), 32'd1);
        check_eq("wr_flag", 32'(s_wr), 32'd1);
        check_eq("wr_addr", 32'(s_addr), 32'h01234);
        check_eq("wr_data", 32'(s_data), 32'hA5);

        // Glitch shorter than the filter length
        tg_we_n = 1'b0;
        cyc(FILT - 1);
        tg_we_n = 1'b1;
        cyc(12);
        check_eq("glitch_level", 32'(level), 32'd0);
        check_eq("glitch_valid", 32'(ev_valid), 32'd0);

        // Overflow: six writes into a four-deep FIFO, nobody reading
        for (int i = 0; i < 6; i++) bus_op(1'b1, 21'(32'h100 + i), 8'(i * 17), 5);
        check_state("ovf");
        check_eq("ovf_level4", 32'(level), 32'd4);
        check_eq("ovf_set", 32'(ovf), 32'd1);
        check_eq("ovf_drop2", 32'(drop_cnt), 32'd2);
        check_eq("ovf_head", 32'(ev_addr), 32'h100);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        model_clear();
        check_eq("clr_ovf", 32'(ovf), 32'd0);
        check_eq("clr_drop", 32'(drop_cnt), 32'd0);
        check_eq("clr_level", 32'(level), 32'd4);

        // Full FIFO: pop in the same cycle the new write is pushed
        tg_a = 21'h00200;
        tg_d = 8'h77;
        tg_we_n = 1'b0;
        cyc(6);
        tg_we_n = 1'b1;
        cyc(2 + FILT);
        ev_ready = 1'b1;
        cyc(1);
        ev_ready = 1'b0;
        void'(q.pop_front());
        model_push(1'b1, 21'h00200, 8'h77);
        check_eq("pp_level", 32'(level), 32'd4);
        check_eq("pp_ovf", 32'(ovf), 32'd0);
        cyc(FILT + 5);
        check_state("pp_late");
        drain("pp_drain");

        // Address window and read capture
        bus_op(1'b1, 21'h100010, 8'h5A, 5);
        check_state("win_out");
        bus_op(1'b0, 21'h00020, 8'hEE, 5);
        check_state("rd");
        drain("rd_drain");

        // Reset in the middle of a write, strobe still low afterwards
        tg_a = 21'h00300;
        tg_d = 8'h33;
        tg_we_n = 1'b0;
        cyc(8);
        RST = 1'b1;
        cyc(2);
        RST = 1'b0;
        q.delete();
        model_clear();
        cyc(20);
        tg_we_n = 1'b1;
        cyc(15);
        check_eq("rstmid_level", 32'(level), 32'd0);
        check_eq("rstmid_valid", 32'(ev_valid), 32'd0);
        check_eq("rstmid_ovf", 32'(ovf), 32'd0);

        // Randomized traffic against the queue model
        for (int it = 0; it < 60; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                drain("rnd_drain");
            end else if (r == 1) begin
                ovf_clr = 1'b1;
                cyc(1);
                ovf_clr = 1'b0;
                model_clear();
                check_state("rnd_clr");
            end else begin
                bit        wr;
                bit [20:0] a;
                bit [7:0]  d;
                int        w;
                wr = ($urandom_range(0, 2) != 0);
                a = {($urandom_range(0, 3) == 0), 20'($urandom)};
                d = 8'($urandom);
                w = int'($urandom_range(1, FILT + 4));
                bus_op(wr, a, d, w);
                check_state("rnd_op");
            end
        end
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tg_bus_event_capture.md
TG_BUS_EVENT_CAPTURE -- requirements
Module: tg_bus_event_capture

Interface
REQ-001 SHALL have parameter FILT, default 3; the number of consecutive synchronized samples needed to accept a strobe level change (range 1..15).
REQ-002 SHALL have parameter DEPTH, default 4; the event FIFO depth (power of two, 2..16).
REQ-003 SHALL have parameter CAP_RD, default 0; when 1, read cycles also generate events.
REQ-004 SHALL have parameters WIN_MASK, default 21'h100000, and WIN_BASE, default 21'h000000; an event is accepted only if (addr & WIN_MASK) == WIN_BASE.
REQ-005 SHALL have the following ports (name, direction, width, meaning); one clock, and reset is synchronous and active-high:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- tg_a  in  21  cartridge address pins (async).
- tg_d  in  8  cartridge data pins, raw pin order (async).
- tg_oe_n  in  1  read strobe (async, active-low).
- tg_we_n  in  1  write strobe (async, active-low).
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer accepts head.
- ev_wr  out  1  1 = write event, 0 = read event.
- ev_addr  out  21  event address.
- ev_data  out  8  write data (0 for reads).
- level  out  5  FIFO occupancy.
- ovf  out  1  sticky overflow flag.
- drop_cnt  out  8  count of dropped events.
- ovf_clr  in  1  clears ovf and drop_cnt.

Function
REQ-006 SHALL pass tg_oe_n and tg_we_n through 2-flop synchronizers; tg_a and tg_d SHALL each pass through one register stage aligned with the second synchronizer flop.
REQ-007 SHALL change the filtered strobe level only after FILT consecutive synchronized samples at the new level; shorter glitches SHALL be ignored.
REQ-008 SHALL implement an FSM with states DISARM, IDLE, WR_ACT and RD_ACT.
REQ-009 In DISARM, the FSM SHALL go to IDLE once both filtered strobes are high.
REQ-010 In IDLE, a filtered write assertion SHALL go to WR_ACT; otherwise a filtered read assertion SHALL go to RD_ACT; if both assert in the same cycle, write wins.
REQ-011 In WR_ACT, address and data SHALL be captured every cycle.
REQ-012 On filtered WE deassertion, WR_ACT SHALL push {wr=1, last captured addr/data} and return to IDLE.
REQ-013 On entry to RD_ACT, if CAP_RD=1, the FSM SHALL push {wr=0, addr, data=0}.
REQ-014 RD_ACT SHALL return to IDLE on filtered OE deassertion.
REQ-015 A WE assertion during RD_ACT SHALL move the FSM to WR_ACT with no second read event.
REQ-016 Events outside the address window SHALL be discarded silently, with no effect on ovf or drop_cnt.
REQ-017 Event latency SHALL be at most 2+FILT+1 CLK cycles from the pin edge to ev_valid.
REQ-018 The FIFO SHALL be first-word-fall-through: the head is presented when ev_valid=1, and a pop occurs on a cycle with ev_valid & ev_ready.
REQ-019 Head outputs SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-020 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full, and level SHALL remain unchanged.
REQ-021 A push while full with no pop SHALL drop the new event, set ovf, and increment drop_cnt, saturating at 255.
REQ-022 ev_ready with an empty FIFO SHALL have no effect.
REQ-023 When ovf_clr coincides with a drop, the clear SHALL win.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.

Reset
REQ-025 While RST=1 at a CLK edge, the block SHALL set:
- FSM to DISARM;
- synchronizer and filter registers to 1 (deasserted);
- filter counters to 0;
- FIFO pointers and level to 0;
- ev_valid, ovf and drop_cnt to 0;
- ev_wr, ev_addr and ev_data to 0.
REQ-026 RST asserted mid-strobe SHALL discard any in-progress capture.
REQ-027 After RST deasserts, a strobe still held low SHALL generate no event until it is seen deasserted for FILT samples (DISARM).

Verification
REQ-028 The bench SHALL cover a write (tg_a=0x01234, tg_d=0xA5, WE low 10 cycles, ev_ready=1) -> exactly one event {wr=1, 0x01234, 0xA5} within 6 cycles of WE rising.
REQ-029 The bench SHALL cover a WE low pulse of FILT-1 cycles -> no event, level stays 0.
REQ-030 The bench SHALL cover, with ev_ready=0 and DEPTH=4, six writes -> level=4, ovf=1, drop_cnt=2; the head is the first write; then ovf_clr -> ovf=0 and drop_cnt=0.
REQ-031 The bench SHALL cover a write to addr 0x100010 -> no event (outside window); with CAP_RD=1, a read of 0x00020 -> {wr=0, 0x00020, 0x00}.
REQ-032 The bench SHALL cover the FIFO full with ev_ready=1 and a new write completing in the same cycle -> level stays 4 and ovf stays 0.
REQ-033 The bench SHALL cover RST pulsed while WE is low, then released with WE still low for 20 cycles, then WE high -> no event generated.
